// File: rtl/trans_chroma.sv
// Luma-dependent chroma transform for the skintone path.
// One pixel in flight; iterative restoring divider, single clock.
module trans_chroma #(
  parameter int DW       = 8,
  parameter int K_L      = 125,
  parameter int K_H      = 188,
  parameter int Y_MIN    = 16,
  parameter int Y_MAX    = 235,
  parameter int C_MID    = 108,
  parameter int W_C      = 47,
  parameter int SLOPE_LO = 23,
  parameter int SLOPE_HI = 54,
  parameter int WB_LO    = 23,
  parameter int WS_LO    = 56,
  parameter int WB_HI    = 14,
  parameter int WS_HI    = 180
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [DW-1:0] in_y,
  input  logic [DW-1:0] in_c,
  input  logic          in_valid,
  output logic          in_ready,
  output logic [DW-1:0] out_c,
  output logic          out_bypass,
  output logic          out_valid,
  input  logic          out_ready
);

  localparam int NB = 2*DW+2;
  localparam int AW = 2*DW+3;
  localparam int CW = $clog2(NB+1);

  localparam logic [DW-1:0] YMIN = DW'(Y_MIN);
  localparam logic [DW-1:0] YMAX = DW'(Y_MAX);
  localparam logic [DW-1:0] KL   = DW'(K_L);
  localparam logic [DW-1:0] KH   = DW'(K_H);
  localparam logic [CW-1:0] CLAST = CW'(NB-1);

  localparam logic signed [AW-1:0] S_KL   = AW'(K_L);
  localparam logic signed [AW-1:0] S_KH   = AW'(K_H);
  localparam logic signed [AW-1:0] S_YMIN = AW'(Y_MIN);
  localparam logic signed [AW-1:0] S_YMAX = AW'(Y_MAX);
  localparam logic signed [AW-1:0] S_MID  = AW'(C_MID);
  localparam logic signed [AW-1:0] S_WC   = AW'(W_C);
  localparam logic signed [AW-1:0] S_SLO  = AW'(SLOPE_LO);
  localparam logic signed [AW-1:0] S_SHI  = AW'(SLOPE_HI);
  localparam logic signed [AW-1:0] S_WBL  = AW'(WB_LO);
  localparam logic signed [AW-1:0] S_WSL  = AW'(WS_LO);
  localparam logic signed [AW-1:0] S_WBH  = AW'(WB_HI);
  localparam logic signed [AW-1:0] S_WSH  = AW'(WS_HI);
  localparam logic signed [AW-1:0] S_ONE  = AW'(1);
  localparam logic signed [AW-1:0] S_CMAX = AW'((1 << DW) - 1);

  typedef enum logic [2:0] {
    IDLE,
    CALC,
    DIV,
    FIN,
    OUT
  } state_e;

  state_e          state_q;
  logic [DW-1:0]   y_q;
  logic [DW-1:0]   c_q;
  logic            sign_q;
  logic [NB-1:0]   dvd_q;
  logic [NB-1:0]   dvs_q;
  logic [NB-1:0]   rem_q;
  logic [CW-1:0]   cnt_q;
  logic [DW-1:0]   out_c_q;
  logic            out_byp_q;
  logic            out_vld_q;

  logic [DW-1:0]          yc_d;
  logic signed [AW-1:0]   ys_d;
  logic signed [AW-1:0]   cs_d;
  logic signed [AW-1:0]   ctr_d;
  logic signed [AW-1:0]   wid_d;
  logic signed [AW-1:0]   num_d;
  logic signed [AW-1:0]   mag_d;
  logic                   byp_d;

  always_comb begin
    yc_d = y_q;
    if (y_q < YMIN) yc_d = YMIN;
    else if (y_q > YMAX) yc_d = YMAX;
    ys_d  = $signed(AW'(yc_d));
    cs_d  = $signed(AW'(c_q));
    byp_d = (yc_d >= KL) && (yc_d <= KH);
    // Slopes are signed Q8; >>> floors toward -inf.
    if (yc_d < KL) begin
      ctr_d = S_MID + (((S_KL - ys_d) * S_SLO) >>> 8);
      wid_d = S_WBL + (((ys_d - S_YMIN) * S_WSL) >>> 8);
    end else begin
      ctr_d = S_MID + (((ys_d - S_KH) * S_SHI) >>> 8);
      wid_d = S_WBH + (((S_YMAX - ys_d) * S_WSH) >>> 8);
    end
    if (wid_d < S_ONE) wid_d = S_ONE;
    num_d = (cs_d - ctr_d) * S_WC;
    mag_d = num_d[AW-1] ? -num_d : num_d;
  end

  logic [NB:0]   rem_sh;
  logic [NB:0]   rem_nx;
  logic          ge;
  logic [NB-1:0] dvd_nx;

  always_comb begin
    rem_sh = {rem_q, dvd_q[NB-1]};
    ge     = rem_sh >= {1'b0, dvs_q};
    rem_nx = ge ? rem_sh - {1'b0, dvs_q} : rem_sh;
    dvd_nx = {dvd_q[NB-2:0], ge};
  end

  logic signed [AW-1:0] q_ext;
  logic signed [AW-1:0] res_d;
  logic [DW-1:0]        sat_d;

  always_comb begin
    q_ext = $signed(AW'(dvd_q));
    res_d = S_MID + (sign_q ? -q_ext : q_ext);
    if (res_d[AW-1]) sat_d = '0;
    else if (res_d > S_CMAX) sat_d = '1;
    else sat_d = DW'(res_d);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      y_q       <= '0;
      c_q       <= '0;
      sign_q    <= 1'b0;
      dvd_q     <= '0;
      dvs_q     <= '0;
      rem_q     <= '0;
      cnt_q     <= '0;
      out_c_q   <= '0;
      out_byp_q <= 1'b0;
      out_vld_q <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (in_valid) begin
            y_q     <= in_y;
            c_q     <= in_c;
            state_q <= CALC;
          end
        end
        CALC: begin
          if (byp_d) begin
            out_c_q   <= c_q;
            out_byp_q <= 1'b1;
            out_vld_q <= 1'b1;
            state_q   <= OUT;
          end else begin
            sign_q  <= num_d[AW-1];
            dvd_q   <= NB'(mag_d);
            dvs_q   <= NB'(wid_d);
            rem_q   <= '0;
            cnt_q   <= '0;
            state_q <= DIV;
          end
        end
        DIV: begin
          rem_q <= NB'(rem_nx);
          dvd_q <= dvd_nx;
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == CLAST) state_q <= FIN;
        end
        FIN: begin
          out_c_q   <= sat_d;
          out_byp_q <= 1'b0;
          out_vld_q <= 1'b1;
          state_q   <= OUT;
        end
        OUT: begin
          if (out_ready) begin
            out_vld_q <= 1'b0;
            state_q   <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign in_ready   = (state_q == IDLE) && !rst;
  assign out_c      = out_c_q;
  assign out_bypass = out_byp_q;
  assign out_valid  = out_vld_q;

endmodule

// File: tb/tb_trans_chroma.sv
// Directed bench for trans_chroma with default Cb parameters.
// Expected values are hand-computed from the transform equations.
module tb_trans_chroma;

  logic       clk;
  logic       rst;
  logic [7:0] in_y;
  logic [7:0] in_c;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] out_c;
  logic       out_bypass;
  logic       out_valid;
  logic       out_ready;

  int tests;
  int fails;

  trans_chroma dut (
    .clk        (clk),
    .rst        (rst),
    .in_y       (in_y),
    .in_c       (in_c),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .out_c      (out_c),
    .out_bypass (out_bypass),
    .out_valid  (out_valid),
    .out_ready  (out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic send(input string tag,
                      input logic [7:0] y,
                      input logic [7:0] c,
                      input logic [7:0] exp_c,
                      input logic exp_b,
                      input int exp_lat);
    int n;
    @(negedge clk);
    check({tag, ".rdy"}, 32'(in_ready), 1);
    in_y     = y;
    in_c     = c;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    n = 1;
    while (!out_valid && n < 100) begin
      @(negedge clk);
      n++;
    end
    check({tag, ".lat"}, n, exp_lat);
    check({tag, ".c"}, 32'(out_c), 32'(exp_c));
    check({tag, ".byp"}, 32'(out_bypass), 32'(exp_b));
    @(negedge clk);
    check({tag, ".vld0"}, 32'(out_valid), 0);
  endtask

  initial begin
    int seen;
    tests     = 0;
    fails     = 0;
    rst       = 1'b1;
    in_y      = '0;
    in_c      = '0;
    in_valid  = 1'b0;
    out_ready = 1'b1;

    repeat (2) @(negedge clk);
    check("rst.vld", 32'(out_valid), 0);
    check("rst.c", 32'(out_c), 0);
    check("rst.byp", 32'(out_bypass), 0);
    check("rst.rdy", 32'(in_ready), 0);
    rst = 1'b0;
    @(negedge clk);
    check("rel.rdy", 32'(in_ready), 1);

    send("byp150", 8'd150, 8'd77, 8'd77, 1'b1, 2);
    send("lo16", 8'd16, 8'd128, 8'd130, 1'b0, 21);
    send("hi235", 8'd235, 8'd100, 8'd51, 1'b0, 21);
    send("sat255", 8'd16, 8'd255, 8'd255, 1'b0, 21);
    send("sat0", 8'd16, 8'd0, 8'd0, 1'b0, 21);
    send("clamp5", 8'd5, 8'd128, 8'd130, 1'b0, 21);
    send("clamp250", 8'd250, 8'd100, 8'd51, 1'b0, 21);
    send("kneeL", 8'd125, 8'd200, 8'd200, 1'b1, 2);
    send("kneeH", 8'd188, 8'd10, 8'd10, 1'b1, 2);
    send("lo124", 8'd124, 8'd150, 8'd150, 1'b0, 21);
    send("hi189", 8'd189, 8'd60, 8'd59, 1'b0, 21);

    out_ready = 1'b0;
    @(negedge clk);
    in_y     = 8'd16;
    in_c     = 8'd128;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (20) @(negedge clk);
    check("bp.vld", 32'(out_valid), 1);
    for (int i = 0; i < 10; i++) begin
      if (i == 3) begin
        in_y     = 8'd150;
        in_c     = 8'd33;
        in_valid = 1'b1;
      end else begin
        in_valid = 1'b0;
      end
      check("bp.hold.vld", 32'(out_valid), 1);
      check("bp.hold.c", 32'(out_c), 130);
      check("bp.hold.byp", 32'(out_bypass), 0);
      check("bp.hold.rdy", 32'(in_ready), 0);
      @(negedge clk);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    check("bp.rel.vld", 32'(out_valid), 0);
    check("bp.rel.rdy", 32'(in_ready), 1);
    seen = 0;
    repeat (6) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    check("bp.nostale", seen, 0);

    @(negedge clk);
    in_y     = 8'd16;
    in_c     = 8'd128;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (9) @(negedge clk);
    rst = 1'b1;
    #1;
    check("mrst.vld", 32'(out_valid), 0);
    check("mrst.c", 32'(out_c), 0);
    check("mrst.rdy", 32'(in_ready), 0);
    @(negedge clk);
    rst = 1'b0;
    seen = 0;
    repeat (25) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    check("mrst.nostale", seen, 0);
    check("mrst.rdy1", 32'(in_ready), 1);
    send("after", 8'd150, 8'd90, 8'd90, 1'b1, 2);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
